// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the program counter, addresses a combinational-read
// instruction memory and registers the fetched word for decode. Handles stall,
// jump/branch redirects, and an Exit/out-of-range drain-then-halt sequence.
//
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   Start                 - begin fetching at address 0 (IDLE and HALT only)
//   Stall                 - freeze PC and output register
//   Jump, Jump_Target     - unconditional redirect (highest priority)
//   Branch_Taken, Branch_Target - taken-branch redirect
//   Instruction, Exit     - same-cycle memory word and "undefined word" flag
//   Instruction_Add       - current PC (word address)
//   Fetched_Instruction   - registered instruction
//   Instr_Valid           - Fetched_Instruction is a real in-path instruction
//   State                 - IDLE=00, RUN=01, DRAIN=10, HALT=11
//   Halted                - State is HALT
//   Fault                 - sticky out-of-range PC/target flag
//   Retired_Count         - saturating count of valid loads
module fetch_sequencer #(
    parameter int unsigned MEM_DEPTH    = 32,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic        Stall,
    input  logic        Jump,
    input  logic [31:0] Jump_Target,
    input  logic        Branch_Taken,
    input  logic [31:0] Branch_Target,
    input  logic [31:0] Instruction,
    input  logic        Exit,
    output logic [31:0] Instruction_Add,
    output logic [31:0] Fetched_Instruction,
    output logic        Instr_Valid,
    output logic [1:0]  State,
    output logic        Halted,
    output logic        Fault,
    output logic [31:0] Retired_Count
);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StDrain = 2'b10,
        StHalt  = 2'b11
    } state_e;

    localparam logic [31:0] Depth     = 32'(MEM_DEPTH);
    localparam logic [31:0] DrainInit = 32'(DRAIN_CYCLES - 1);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fetched_q, fetched_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;
    logic [31:0] retired_q, retired_d;
    logic [31:0] drain_q, drain_d;
    logic [31:0] pc_inc;
    logic [31:0] target;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        fetched_d = fetched_q;
        valid_d   = valid_q;
        fault_d   = fault_q;
        retired_d = retired_q;
        drain_d   = drain_q;
        pc_inc    = pc_q + 32'd1;
        target    = Jump ? Jump_Target : Branch_Target;

        case (state_q)
            StIdle: begin
                if (Start) begin
                    state_d = StRun;
                    pc_d    = '0;
                end
            end
            StRun: begin
                if (Jump || Branch_Taken) begin
                    // Word at the current PC is wrong-path; Exit is irrelevant here.
                    valid_d = 1'b0;
                    if (target >= Depth) begin
                        fault_d = 1'b1;
                        state_d = StDrain;
                        drain_d = DrainInit;
                    end else begin
                        pc_d = target;
                    end
                end else if (Exit) begin
                    valid_d = 1'b0;
                    state_d = StDrain;
                    drain_d = DrainInit;
                end else if (!Stall) begin
                    fetched_d = Instruction;
                    valid_d   = 1'b1;
                    if (retired_q != 32'hFFFF_FFFF) begin
                        retired_d = retired_q + 32'd1;
                    end
                    // Last word is still retired; PC stays on it while draining.
                    if (pc_inc == Depth) begin
                        fault_d = 1'b1;
                        state_d = StDrain;
                        drain_d = DrainInit;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
            StDrain: begin
                valid_d = 1'b0;
                if (drain_q == 32'd0) begin
                    state_d = StHalt;
                end else begin
                    drain_d = drain_q - 32'd1;
                end
            end
            StHalt: begin
                if (Start) begin
                    state_d   = StRun;
                    pc_d      = '0;
                    fault_d   = 1'b0;
                    retired_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            pc_q      <= '0;
            fetched_q <= '0;
            valid_q   <= 1'b0;
            fault_q   <= 1'b0;
            retired_q <= '0;
            drain_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            fetched_q <= fetched_d;
            valid_q   <= valid_d;
            fault_q   <= fault_d;
            retired_q <= retired_d;
            drain_q   <= drain_d;
        end
    end

    assign Instruction_Add     = pc_q;
    assign Fetched_Instruction = fetched_q;
    assign Instr_Valid         = valid_q;
    assign State               = state_q;
    assign Halted              = (state_q == StHalt);
    assign Fault               = fault_q;
    assign Retired_Count       = retired_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a combinational instruction memory
// model; expected post-edge outputs are queued before each edge and checked after.
module tb_fetch_sequencer;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] RUN   = 2'b01;
    localparam logic [1:0] DRAIN = 2'b10;
    localparam logic [1:0] HALT  = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic        Stall;
    logic        Jump;
    logic [31:0] Jump_Target;
    logic        Branch_Taken;
    logic [31:0] Branch_Target;
    logic [31:0] Instruction;
    logic        Exit;
    logic [31:0] Instruction_Add;
    logic [31:0] Fetched_Instruction;
    logic        Instr_Valid;
    logic [1:0]  State;
    logic        Halted;
    logic        Fault;
    logic [31:0] Retired_Count;

    logic [31:0] mem [64];
    logic [31:0] prog_n;

    int checks = 0;
    int errors = 0;
    int step_no = 0;

    typedef struct {
        logic [1:0]  st;
        logic [31:0] pc;
        logic        v;
        logic [31:0] fi;
        logic [31:0] rc;
        logic        f;
    } exp_t;

    exp_t sbq[$];

    fetch_sequencer #(
        .MEM_DEPTH   (32),
        .DRAIN_CYCLES(4)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .Start              (Start),
        .Stall              (Stall),
        .Jump               (Jump),
        .Jump_Target        (Jump_Target),
        .Branch_Taken       (Branch_Taken),
        .Branch_Target      (Branch_Target),
        .Instruction        (Instruction),
        .Exit               (Exit),
        .Instruction_Add    (Instruction_Add),
        .Fetched_Instruction(Fetched_Instruction),
        .Instr_Valid        (Instr_Valid),
        .State              (State),
        .Halted             (Halted),
        .Fault              (Fault),
        .Retired_Count      (Retired_Count)
    );

    always #5 clk = ~clk;

    // Memory: words below prog_n are programmed, everything above flags Exit.
    always_comb begin
        Instruction = 32'h0;
        Exit        = (Instruction_Add >= prog_n);
        if (Instruction_Add < 32'd64) begin
            Instruction = mem[Instruction_Add[5:0]];
        end
    end

    function automatic logic [31:0] w(input int a);
        return 32'hA000_0000 + 32'(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL step %0d %s: observed %h expected %h", step_no, tag, obs, expv);
        end
    endtask

    // Queue the expected post-edge state, advance one edge, then compare.
    task automatic step(input logic [1:0] st, input logic [31:0] pc, input logic v,
                        input logic [31:0] fi, input logic [31:0] rc, input logic f);
        exp_t e;
        exp_t got;
        e.st = st; e.pc = pc; e.v = v; e.fi = fi; e.rc = rc; e.f = f;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        step_no++;
        got = sbq.pop_front();
        chk("State", {30'b0, State}, {30'b0, got.st});
        chk("Instruction_Add", Instruction_Add, got.pc);
        chk("Instr_Valid", {31'b0, Instr_Valid}, {31'b0, got.v});
        chk("Fetched_Instruction", Fetched_Instruction, got.fi);
        chk("Retired_Count", Retired_Count, got.rc);
        chk("Fault", {31'b0, Fault}, {31'b0, got.f});
        chk("Halted", {31'b0, Halted}, {31'b0, (got.st == HALT)});
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = w(i);
        prog_n        = 32'd3;
        reset         = 1'b1;
        Start         = 1'b0;
        Stall         = 1'b0;
        Jump          = 1'b0;
        Jump_Target   = 32'd0;
        Branch_Taken  = 1'b0;
        Branch_Target = 32'd0;

        // Reset and IDLE hold.
        step(IDLE, 0, 0, 0, 0, 0);
        step(IDLE, 0, 0, 0, 0, 0);
        reset = 1'b0;
        step(IDLE, 0, 0, 0, 0, 0);

        // Three programmed words, Exit at PC=3, four DRAIN cycles, HALT.
        Start = 1'b1;
        step(RUN, 0, 0, 0, 0, 0);
        Start = 1'b0;
        step(RUN, 1, 1, w(0), 1, 0);
        step(RUN, 2, 1, w(1), 2, 0);
        step(RUN, 3, 1, w(2), 3, 0);
        step(DRAIN, 3, 0, w(2), 3, 0);
        Start = 1'b1;  // ignored while draining
        step(DRAIN, 3, 0, w(2), 3, 0);
        step(DRAIN, 3, 0, w(2), 3, 0);
        step(DRAIN, 3, 0, w(2), 3, 0);
        step(HALT, 3, 0, w(2), 3, 0);
        Start = 1'b0;
        step(HALT, 3, 0, w(2), 3, 0);

        // Restart from HALT, stall two cycles at PC=1.
        prog_n = 32'd32;
        Start  = 1'b1;
        step(RUN, 0, 0, w(2), 0, 0);
        Start = 1'b0;
        step(RUN, 1, 1, w(0), 1, 0);
        Stall = 1'b1;
        step(RUN, 1, 1, w(0), 1, 0);
        step(RUN, 1, 1, w(0), 1, 0);
        Stall = 1'b0;
        step(RUN, 2, 1, w(1), 2, 0);

        // Jump and Branch together at PC=2: Jump wins, one bubble.
        Jump = 1'b1; Jump_Target = 32'd5;
        Branch_Taken = 1'b1; Branch_Target = 32'd9;
        step(RUN, 5, 0, w(1), 2, 0);
        Jump = 1'b0; Branch_Taken = 1'b0;
        step(RUN, 6, 1, w(5), 3, 0);

        // Branch with Exit at the same PC: redirect taken, no DRAIN.
        prog_n = 32'd6;
        Branch_Taken = 1'b1; Branch_Target = 32'd10;
        step(RUN, 10, 0, w(5), 3, 0);
        Branch_Taken = 1'b0;
        prog_n = 32'd32;
        step(RUN, 11, 1, w(10), 4, 0);

        // Out-of-range branch target: Fault, PC holds, DRAIN then HALT.
        Branch_Taken = 1'b1; Branch_Target = 32'd40;
        step(DRAIN, 11, 0, w(10), 4, 1);
        Branch_Taken = 1'b0;
        step(DRAIN, 11, 0, w(10), 4, 1);
        step(DRAIN, 11, 0, w(10), 4, 1);
        step(DRAIN, 11, 0, w(10), 4, 1);
        step(HALT, 11, 0, w(10), 4, 1);

        // Restart clears Fault and count; run off the end of a full memory.
        Start = 1'b1;
        step(RUN, 0, 0, w(10), 0, 0);
        Start = 1'b0;
        for (int a = 0; a < 31; a++) begin
            step(RUN, 32'(a + 1), 1, w(a), 32'(a + 1), 0);
        end
        step(DRAIN, 31, 1, w(31), 32, 1);
        step(DRAIN, 31, 0, w(31), 32, 1);
        step(DRAIN, 31, 0, w(31), 32, 1);
        step(DRAIN, 31, 0, w(31), 32, 1);
        step(HALT, 31, 0, w(31), 32, 1);
        Start = 1'b1;
        step(RUN, 0, 0, w(31), 0, 0);
        Start = 1'b0;

        // Reset on the second DRAIN cycle; Start during DRAIN has no effect.
        step(RUN, 1, 1, w(0), 1, 0);
        prog_n = 32'd1;
        step(DRAIN, 1, 0, w(0), 1, 0);
        Start = 1'b1;
        step(DRAIN, 1, 0, w(0), 1, 0);
        reset = 1'b1;
        step(IDLE, 0, 0, 0, 0, 0);
        reset = 1'b0;
        Start = 1'b0;
        step(IDLE, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Owns the program counter and drives the word address of the instruction memory, which has a combinational read and an Exit flag for unprogrammed words.
- Registers the fetched word for decode.
- Applies stall and branch/jump redirects.
- On Exit or an out-of-range PC, drains the pipeline, then halts.

Parameters:
MEM_DEPTH, 32, number of instruction words; valid PC range is 0..MEM_DEPTH-1
DRAIN_CYCLES, 4, cycles spent in DRAIN before HALT (at least 1)

Ports:
clk  input  1  system clock, all state changes on rising edge
reset  input  1  synchronous, active-high
Start  input  1  begin fetching from address 0 (honoured in IDLE and HALT)
Stall  input  1  downstream hazard; freeze PC and output register
Jump  input  1  unconditional redirect request
Jump_Target  input  32  word address for Jump
Branch_Taken  input  1  taken-branch redirect request
Branch_Target  input  32  word address for Branch_Taken
Instruction  input  32  word read from the instruction memory (same-cycle)
Exit  input  1  memory flag: word at current address is undefined
Instruction_Add  output  32  current PC, word address to the memory
Fetched_Instruction  output  32  registered instruction for decode
Instr_Valid  output  1  Fetched_Instruction is a real, in-path instruction
State  output  2  IDLE=00, RUN=01, DRAIN=10, HALT=11
Halted  output  1  high when State is HALT
Fault  output  1  sticky: PC or target left 0..MEM_DEPTH-1
Retired_Count  output  32  count of cycles where Instr_Valid was loaded as 1; saturates at 32'hFFFFFFFF

Behaviour:
- Reset (synchronous, next edge, from any state including mid-DRAIN):
  - State=IDLE; Instruction_Add=0; Fetched_Instruction=0; Instr_Valid=0.
  - Halted=0; Fault=0; Retired_Count=0; drain counter=0.
- IDLE:
  - Outputs hold reset values.
  - Start -> RUN with PC=0; no fetch is registered on this edge.
- RUN: per-cycle priority, highest first.
  - 1. Jump: PC<=Jump_Target; Instr_Valid<=0 (current word is wrong-path, squashed); Exit ignored.
  - 2. Branch_Taken (no Jump): same as Jump with Branch_Target. A simultaneous Jump wins.
  - 3. Exit: -> DRAIN; Instr_Valid<=0; PC holds; drain counter<=DRAIN_CYCLES-1.
  - 4. Stall: PC, Fetched_Instruction and Instr_Valid all hold; Retired_Count holds.
  - 5. Otherwise: Fetched_Instruction<=Instruction; Instr_Valid<=1; Retired_Count+1 (saturating); PC<=PC+1.
- Out-of-range handling:
  - A redirect target >= MEM_DEPTH: Fault<=1, -> DRAIN, PC holds the old value.
  - PC+1 == MEM_DEPTH on a sequential step: the instruction is still registered valid, then Fault<=1 and -> DRAIN.
- Latency:
  - Instruction at address A appears on Fetched_Instruction one edge after Instruction_Add=A in an unstalled, unredirected cycle.
  - A redirect costs exactly one bubble.
- DRAIN:
  - Instr_Valid<=0 every cycle; PC frozen; all inputs except reset ignored.
  - Drain counter decrements each cycle; at 0 -> HALT.
- HALT:
  - Halted=1; PC, Fetched_Instruction and Retired_Count frozen; Fault retained.
  - Start: Retired_Count<=0, Fault<=0, PC<=0, -> RUN.
- Width and data rules:
  - PC arithmetic is 32-bit unsigned; range checks are unsigned compares.
  - Exit is sampled only in RUN.
  - Instruction is never registered in a cycle where Exit=1.

Test Plan:
- Memory holds 3 words then undefined; reset, Start.
  - Required: Instr_Valid for addresses 0,1,2 on consecutive edges.
  - Required: Exit at PC=3 -> DRAIN for 4 cycles -> HALT; Retired_Count=3; Instruction_Add=3.
- Stall high for 2 cycles at PC=1 -> Instruction_Add stays 1; Fetched_Instruction holds word 0; Retired_Count unchanged. Fetch of address 1 resumes after Stall drops.
- Jump_Target=5 and Branch_Target=9 asserted together at PC=2 -> next PC=5; Instr_Valid=0 for one cycle; word 5 valid on the following edge.
- Branch_Taken with Exit=1 at the same PC -> redirect taken, no DRAIN. Branch_Target=40 with MEM_DEPTH=32 -> Fault=1, DRAIN, then HALT.
- Fully programmed memory, no branches -> PC 31 registered valid, then Fault=1, DRAIN, HALT. In HALT, Start -> PC=0, Fault=0, Retired_Count=0, State=RUN.
- reset asserted on the 2nd DRAIN cycle -> next edge State=IDLE, all outputs at reset values. Start during DRAIN before the reset has no effect.
